// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants and the IF/ID register layout
package cpu_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: pipeline register with flush-over-stall priority; a flush inserts a NOP bubble but keeps pc/pc4
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   stall_i,
    input  logic   flush_i,
    input  if_id_t d_i,
    output if_id_t q_o
);
    if_id_t r_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '{instr: NOP_INSTR, pc: '0, pc4: '0, valid: 1'b0};
        end else if (flush_i) begin
            r_q.instr <= NOP_INSTR;
            r_q.valid <= 1'b0;
        end else if (!stall_i) begin
            r_q <= d_i;
        end
    end
    assign q_o = r_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: program counter, instruction fetch and IF/ID capture with stall/flush/redirect
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_pc4_o,
    output logic        id_valid_o,
    output logic [31:0] fetch_cnt_o
);
    logic [31:0] r_pc, r_cnt, w_pc4;
    logic        w_bubble, w_load;
    if_id_t      w_d, w_q;
    assign w_pc4    = r_pc + 32'd4;
    assign w_bubble = redirect_i | flush_i;
    assign w_load   = !w_bubble && !stall_i;
    // redirect wins over stall so a resolved branch is never dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc  <= RESET_PC;
            r_cnt <= '0;
        end else begin
            r_pc <= redirect_i ? (redirect_pc_i & ~32'h3) : stall_i ? r_pc : w_pc4;
            if (w_load) r_cnt <= r_cnt + 32'd1;
        end
    end
    assign w_d = '{instr: imem_rdata_i, pc: r_pc, pc4: w_pc4, valid: 1'b1};
    if_id_reg u_if_id (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .stall_i (stall_i),
        .flush_i (w_bubble),
        .d_i     (w_d),
        .q_o     (w_q)
    );
    // word-index field split out to mark where the memory decodes; higher bits alias
    assign imem_addr_o = {r_pc[31:IMEM_AW+2], r_pc[IMEM_AW+1:2], r_pc[1:0]};
    assign if_pc_o     = r_pc;
    assign id_instr_o  = w_q.instr;
    assign id_pc_o     = w_q.pc;
    assign id_pc4_o    = w_q.pc4;
    assign id_valid_o  = w_q.valid;
    assign fetch_cnt_o = r_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a behavioural model
module tb_fetch_stage;
    localparam int          IMEM_AW = 12;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0, redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] imem_addr_o, imem_rdata_i, if_pc_o, id_instr_o, id_pc_o, id_pc4_o, fetch_cnt_o;
    logic        id_valid_o;
    logic [31:0] mem [0:(1<<IMEM_AW)-1];
    logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_cnt;
    logic        m_valid;
    int          vecs = 0, errs = 0;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(IMEM_AW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .flush_i(flush_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i), .if_pc_o(if_pc_o),
        .id_instr_o(id_instr_o), .id_pc_o(id_pc_o), .id_pc4_o(id_pc4_o),
        .id_valid_o(id_valid_o), .fetch_cnt_o(fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    assign imem_rdata_i = mem[imem_addr_o[IMEM_AW+1:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  imem_addr_o, m_pc);
        check({tag, ".ifpc"},  if_pc_o,     m_pc);
        check({tag, ".instr"}, id_instr_o,  m_instr);
        check({tag, ".idpc"},  id_pc_o,     m_id_pc);
        check({tag, ".pc4"},   id_pc4_o,    m_id_pc4);
        check({tag, ".valid"}, {31'b0, id_valid_o}, {31'b0, m_valid});
        check({tag, ".cnt"},   fetch_cnt_o, m_cnt);
    endtask

    // one clock: drive controls on the falling edge, apply the fetch rules at the rising edge
    task automatic cycle(input string tag, input logic st, input logic fl, input logic rd, input logic [31:0] tgt);
        logic [31:0] fetched;
        @(negedge clk_i);
        stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = tgt;
        @(posedge clk_i);
        fetched = mem[m_pc[IMEM_AW+1:2]];
        if (rd || fl) begin
            m_instr = NOP; m_valid = 0;
        end else if (!st) begin
            m_instr = fetched; m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_valid = 1; m_cnt++;
        end
        m_pc = rd ? {tgt[31:2], 2'b00} : st ? m_pc : m_pc + 4;
        #1 check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = i;
        model_reset();
        #12 check_all("reset");
        @(posedge clk_i); #2 rst_ni = 1'b1;
        #1 check_all("release");
        check("first_valid", {31'b0, id_valid_o}, 32'd0);
        cycle("run0", 0, 0, 0, 0);
        check("run0.instr", id_instr_o, 32'd0);
        check("run0.addr", imem_addr_o, 32'd4);
        cycle("run1", 0, 0, 0, 0);
        check("run1.instr", id_instr_o, 32'd1);
        cycle("run2", 0, 0, 0, 0);
        check("run2.instr", id_instr_o, 32'd2);
        check("run2.addr", imem_addr_o, 32'd12);
        check("run2.cnt", fetch_cnt_o, 32'd3);
        cycle("run3", 0, 0, 0, 0);
        check("pc10", if_pc_o, 32'h10);
        cycle("stall0", 1, 0, 0, 0);
        cycle("stall1", 1, 0, 0, 0);
        check("stall.pc", if_pc_o, 32'h10);
        check("stall.cnt", fetch_cnt_o, 32'd4);
        cycle("unstall", 0, 0, 0, 0);
        check("unstall.pc", if_pc_o, 32'h14);
        repeat (3) cycle("to20", 0, 0, 0, 0);
        check("pc20", if_pc_o, 32'h20);
        cycle("redir", 0, 0, 1, 32'h103);
        check("redir.pc", if_pc_o, 32'h100);
        check("redir.instr", id_instr_o, NOP);
        cycle("tgt", 0, 0, 0, 0);
        check("tgt.idpc", id_pc_o, 32'h100);
        check("tgt.pc4", id_pc4_o, 32'h104);
        cycle("redir_stall", 1, 0, 1, 32'h40);
        check("redir_stall.pc", if_pc_o, 32'h40);
        cycle("flush", 0, 1, 0, 0);
        check("flush.pc", if_pc_o, 32'h44);
        cycle("all4", 1, 1, 1, 32'h0000_0202);
        cycle("to_top", 0, 0, 1, 32'hFFFF_FFFC);
        cycle("wrap", 0, 0, 0, 0);
        check("wrap.pc", if_pc_o, 32'h0);
        check("wrap.pc4", id_pc4_o, 32'h0);
        cycle("post_wrap", 0, 0, 0, 0);
        #2 rst_ni = 1'b0;
        model_reset();
        #1 check_all("midreset");
        @(posedge clk_i); #2 rst_ni = 1'b1;
        #1 check_all("midrelease");
        for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
            cycle("rand", $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 7) == 0, tgt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage non-forwarding pipeline, directly upstream of the instruction memory.
- Holds the program counter and drives the combinational-read instruction memory address.
- Captures the returned word into the IF/ID pipeline register for decode.
- Services stall requests from the hazard unit and redirect/flush requests from the EX-stage branch/jump resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 12, word-address width of the instruction memory; the memory index is pc[IMEM_AW+1:2].

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- stall_i  input  1  hazard unit: hold PC and IF/ID.
- flush_i  input  1  squash IF/ID contents (bubble), PC unaffected.
- redirect_i  input  1  taken branch/jump resolved in EX.
- redirect_pc_i  input  32  target address for redirect_i.
- imem_addr_o  output  32  byte address to instruction memory.
- imem_rdata_i  input  32  instruction word from memory, same cycle.
- if_pc_o  output  32  current PC (IF stage), for debug/trace.
- id_instr_o  output  32  IF/ID instruction.
- id_pc_o  output  32  IF/ID PC of that instruction.
- id_pc4_o  output  32  IF/ID PC+4 (link value for JAL/JALR).
- id_valid_o  output  1  IF/ID holds a real instruction.
- fetch_cnt_o  output  32  count of instructions accepted into IF/ID.

Behaviour:
- Reset (async, rst_ni low): pc_q=RESET_PC; id_instr_o=NOP (32'h0000_0013); id_pc_o=0; id_pc4_o=0; id_valid_o=0; fetch_cnt_o=0. Reset asserted mid-operation discards all state immediately, without waiting for a clock edge.
- imem_addr_o = pc_q, combinational. if_pc_o = pc_q. The memory read is combinational, so IF→IF/ID latency is 1 cycle.
- PC update priority per rising edge:
  - redirect_i: pc_q <= {redirect_pc_i[31:2],2'b00}.
  - else stall_i: hold.
  - else pc_q <= pc_q+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
  - Redirect overrides stall, so a stall never loses a resolved branch.
- IF/ID update priority per rising edge:
  - redirect_i or flush_i: id_instr_o<=NOP, id_valid_o<=0; id_pc_o and id_pc4_o hold their values.
  - else stall_i: hold all IF/ID fields.
  - else: id_instr_o<=imem_rdata_i, id_pc_o<=pc_q, id_pc4_o<=pc_q+4, id_valid_o<=1.
- fetch_cnt_o increments by 1 exactly on the edges where IF/ID loads with id_valid_o<=1. It wraps at 2^32.
- First fetch: in the first cycle after reset release, id_valid_o=0. The first edge loads the word at RESET_PC.
- Redirect penalty: the instruction fetched in the redirect cycle is squashed. The target enters IF/ID on the edge after the redirect, so there is exactly one bubble from this stage. Upstream flush of ID comes from flush_i.
- The PC is not range-checked. Addresses beyond 2^(IMEM_AW+2) bytes alias in memory by design.
- All four controls may be asserted in the same cycle. The priorities above fully define the outcome.

Decomposition:
- Shared package cpu_pkg:
  - NOP_INSTR = 32'h0000_0013.
  - RESET_PC default.
  - Packed struct if_id_t {instr, pc, pc4, valid}, reused by the decode stage.
- One natural sub-module: if_id_reg.
  - Contents: the IF/ID register with flush/stall priority and async reset to the NOP bubble.
  - Reuse: the same structure is used for the ID/EX register.
- PC register and counter stay in fetch_stage.

Test Plan:
- Reset release, no stall, memory preloaded with word i = i:
  - imem_addr_o steps 0,4,8,12.
  - id_instr_o = 0,1,2 on cycles 1,2,3, with id_valid_o=1 from cycle 1.
  - fetch_cnt_o=3 after 3 loads.
- stall_i high for 2 cycles with pc_q=0x10:
  - pc_q, id_instr_o and fetch_cnt_o hold for 2 cycles.
  - The next cycle has pc_q=0x14.
- redirect_i with redirect_pc_i=0x103 while pc_q=0x20:
  - Next pc_q=0x100 and id_valid_o=0 with id_instr_o=NOP.
  - Following edge: id_pc_o=0x100, id_pc4_o=0x104, valid=1.
- redirect_i and stall_i asserted together: PC takes the target, IF/ID bubbles, fetch_cnt_o unchanged.
- flush_i alone at pc_q=0x40: IF/ID bubble, pc_q advances to 0x44.
- pc_q=0xFFFF_FFFC, no stall: next pc_q=0x0 and id_pc4_o=0x0. Mid-run rst_ni pulse between edges: outputs return to reset values immediately.
